pipe_hazard_ctrl: RTL

//  Pipeline sequencer for the ID/EX boundary. Generates PC/IF-ID stall and

---
 rtl/pipe_hazard_ctrl_if.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 74 +++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard-unit signals between the ID/EX/MEM pipeline and its sequencer
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [4:0]       id_rs, id_rt;
    logic             id_use_rs, id_use_rt, id_is_store, id_mc_start;
    logic             ex_wreg, ex_m2reg;
    logic [4:0]       ex_wn;
    logic             mem_wreg;
    logic [4:0]       mem_wn;
    logic             ex_jump_taken;
    logic             pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_hold;
    logic [1:0]       fwd_a, fwd_b;
    logic             is_store_hazard, mc_busy;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_is_store, id_mc_start,
               ex_wreg, ex_m2reg, ex_wn, mem_wreg, mem_wn, ex_jump_taken,
        input  pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_hold,
               fwd_a, fwd_b, is_store_hazard, mc_busy, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_is_store, id_mc_start,
               ex_wreg, ex_m2reg, ex_wn, mem_wreg, mem_wn, ex_jump_taken,
        output pc_stall, ifid_stall, ifid_flush, idex_bubble, idex_hold,
               fwd_a, fwd_b, is_store_hazard, mc_busy, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: ID/EX stall/flush/bubble/hold sequencing, forwarding selects and multicycle-op hold
module pipe_hazard_ctrl #(
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input logic               clk,
    input logic               clrn,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int            CW      = MC_LATENCY > 1 ? $clog2(MC_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INI = CW'(MC_LATENCY - 1);
    localparam bit            MC_EN   = MC_LATENCY > 1;

    typedef enum logic {RUN, MC} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic             load_use, in_mc, mc_stall, jump, lu_stall, accept, pc_stall;
    logic [1:0]       fa, fb;

    function automatic logic [1:0] fwd_sel(input logic [4:0] s, input logic ew, input logic em,
                                           input logic [4:0] ewn, input logic mw, input logic [4:0] mwn);
        return (ew && !em && ewn != 5'd0 && ewn == s) ? 2'b01 :
               (mw && mwn != 5'd0 && mwn == s)        ? 2'b10 : 2'b00;
    endfunction

    // Hazard detection; a jump outranks a load-use stall, which outranks accepting a multicycle op
    always_comb begin
        fa       = fwd_sel(bus.id_rs, bus.ex_wreg, bus.ex_m2reg, bus.ex_wn, bus.mem_wreg, bus.mem_wn);
        fb       = fwd_sel(bus.id_rt, bus.ex_wreg, bus.ex_m2reg, bus.ex_wn, bus.mem_wreg, bus.mem_wn);
        load_use = bus.ex_wreg && bus.ex_m2reg && bus.ex_wn != 5'd0 &&
                   ((bus.id_use_rs && bus.ex_wn == bus.id_rs) || (bus.id_use_rt && bus.ex_wn == bus.id_rt));
        in_mc    = state == MC;
        mc_stall = in_mc && cnt != '0;
        jump     = !in_mc && bus.ex_jump_taken;
        lu_stall = !in_mc && !bus.ex_jump_taken && load_use;
        accept   = MC_EN && !in_mc && !bus.ex_jump_taken && !load_use && bus.id_mc_start;
        pc_stall = clrn && (lu_stall || mc_stall);
    end

    // Outputs are forced low while reset is asserted so an abort takes effect without waiting for a clock
    always_comb begin
        bus.pc_stall        = pc_stall;
        bus.ifid_stall      = pc_stall;
        bus.ifid_flush      = clrn && jump;
        bus.idex_bubble     = clrn && (jump || lu_stall);
        bus.idex_hold       = clrn && mc_stall;
        bus.fwd_a           = clrn ? fa : 2'b00;
        bus.fwd_b           = clrn ? fb : 2'b00;
        bus.is_store_hazard = clrn && bus.id_is_store && fb != 2'b00;
        bus.mc_busy         = clrn && in_mc;
        bus.stall_cycles    = stall_cnt;
    end

    // Sequencer state, multicycle countdown and saturating stall-cycle counter
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state     <= RUN;
            cnt       <= '0;
            stall_cnt <= '0;
        end else begin
            if (in_mc) begin
                state <= cnt == '0 ? RUN : MC;
                cnt   <= cnt == '0 ? cnt : cnt - 1'b1;
            end else if (accept) begin
                state <= MC;
                cnt   <= CNT_INI;
            end
            if (pc_stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule
